vlc_frame_serializer: RTL and testbench

Transmit-side framing and line-coding stage that drains the byte output of the transmitter's codeword buffer and drives the LED modulation line. On `start` it emits a fixed preamble and a start-of-frame delimiter (SFD), then pops exactly `PAYLOAD_BYTES` bytes from the buffer and serialises them MSB-first. Each bit is line-coded onto `ledOut` with a configurable half-bit period. It sits between the buffer's `shiftOut`/`pop` pair and the LED driver.

---
 rtl/vlc_frame_serializer.sv | 172 +++++++++++++++++
 tb/tb_vlc_frame_serializer.sv | 148 ++++++++++++++
 2 files changed

// File: rtl/vlc_frame_serializer.sv
// Frame serializer: preamble, SFD, then PAYLOAD_BYTES popped bytes, MSB-first onto ledOut.
// Define MANCHESTER_EN for Manchester line coding; otherwise NRZ on-off keying.
module vlc_frame_serializer #(
  parameter int unsigned CLKS_PER_HALF  = 4,
  parameter int unsigned PREAMBLE_BYTES = 4,
  parameter int unsigned PAYLOAD_BYTES  = 8,
  parameter logic [7:0]  SFD            = 8'hA7
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic [7:0] byteIn,
  input  logic       byteValid,
  output logic       pop,
  output logic       ledOut,
  output logic       busy,
  output logic       done,
  output logic       underrun
);

  localparam int unsigned HW      = $clog2(CLKS_PER_HALF);
  localparam int unsigned CNT_MAX = (PREAMBLE_BYTES > PAYLOAD_BYTES) ? PREAMBLE_BYTES : PAYLOAD_BYTES;
  localparam int unsigned CW      = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
  localparam logic [HW-1:0] HALF_LAST = HW'(CLKS_PER_HALF - 1);
  localparam logic [CW-1:0] PRE_LAST  = CW'(PREAMBLE_BYTES - 1);
  localparam logic [CW-1:0] PAY_LAST  = CW'(PAYLOAD_BYTES - 1);

  typedef enum logic [1:0] {ST_IDLE, ST_PREAMBLE, ST_SFD, ST_PAYLOAD} state_e;

  state_e        state_q, state_d;
  logic [7:0]    byte_q, byte_d;
  logic [7:0]    next_q, next_d;
  logic [2:0]    bit_q, bit_d;
  logic [HW-1:0] half_cnt_q, half_cnt_d;
  logic          phase_q, phase_d;
  logic [CW-1:0] byte_cnt_q, byte_cnt_d;
  logic          cap_q;
  logic          led_q, led_d;
  logic          pop_q, pop_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;
  logic          underrun_q, underrun_d;
  logic          half_end, bit_end;

  // Registered outputs are computed from the position being entered, so
  // pop/underrun land on the first cycle of bit 0 using byteValid from the cycle before.
  always_comb begin
    // NOTE: every comb output gets a default first so no path can infer a latch.
    state_d    = state_q;
    byte_d     = byte_q;
    next_d     = next_q;
    bit_d      = bit_q;
    half_cnt_d = half_cnt_q;
    phase_d    = phase_q;
    byte_cnt_d = byte_cnt_q;
    pop_d      = 1'b0;
    done_d     = 1'b0;
    underrun_d = 1'b0;
    half_end   = (half_cnt_q == HALF_LAST);
    bit_end    = half_end && phase_q;

    case (state_q)
      ST_IDLE: begin
        // A start seen while done is still pulsing belongs to the finished frame.
        if (start && !done_q) begin
          state_d    = ST_PREAMBLE;
          byte_d     = 8'h55;
          byte_cnt_d = '0;
          bit_d      = 3'd7;
          half_cnt_d = '0;
          phase_d    = 1'b0;
        end
      end
      default: begin
        half_cnt_d = half_end ? '0 : half_cnt_q + HW'(1);
        if (half_end) phase_d = ~phase_q;
        if (bit_end) begin
          if (bit_q != 3'd0) begin
            bit_d = bit_q - 3'd1;
          end else begin
            bit_d      = 3'd7;
            byte_cnt_d = byte_cnt_q + CW'(1);
            case (state_q)
              ST_PREAMBLE: begin
                if (byte_cnt_q == PRE_LAST) begin
                  state_d    = ST_SFD;
                  byte_d     = SFD;
                  byte_cnt_d = '0;
                end else begin
                  byte_d = 8'h55;
                end
              end
              ST_SFD: begin
                state_d    = ST_PAYLOAD;
                byte_d     = next_q;
                byte_cnt_d = '0;
              end
              default: begin
                if (byte_cnt_q == PAY_LAST) begin
                  state_d = ST_IDLE;
                  done_d  = 1'b1;
                end else begin
                  byte_d = next_q;
                end
              end
            endcase
          end
          if (bit_q == 3'd1 &&
              (state_q == ST_SFD || (state_q == ST_PAYLOAD && byte_cnt_q != PAY_LAST))) begin
            if (byteValid) begin
              pop_d = 1'b1;
            end else begin
              state_d    = ST_IDLE;
              underrun_d = 1'b1;
            end
          end
        end
      end
    endcase

    // Buffer presents the byte the cycle after it sees pop.
    if (cap_q) next_d = byteIn;

    busy_d = (state_d != ST_IDLE);
`ifdef MANCHESTER_EN
    led_d = busy_d & (byte_d[bit_d] ^ phase_d);
`else
    led_d = busy_d & byte_d[bit_d];
`endif
  end

  // NOTE: sequential state uses non-blocking assignments only, so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      byte_q     <= '0;
      // NOTE: the next-byte register is reset too; it is a single register, not a memory array.
      next_q     <= '0;
      bit_q      <= '0;
      half_cnt_q <= '0;
      phase_q    <= 1'b0;
      byte_cnt_q <= '0;
      cap_q      <= 1'b0;
      led_q      <= 1'b0;
      pop_q      <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      underrun_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      byte_q     <= byte_d;
      next_q     <= next_d;
      bit_q      <= bit_d;
      half_cnt_q <= half_cnt_d;
      phase_q    <= phase_d;
      byte_cnt_q <= byte_cnt_d;
      cap_q      <= pop_q;
      led_q      <= led_d;
      pop_q      <= pop_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      underrun_q <= underrun_d;
    end
  end

  assign pop      = pop_q;
  assign ledOut   = led_q;
  assign busy     = busy_q;
  assign done     = done_q;
  assign underrun = underrun_q;

endmodule

// File: tb/tb_vlc_frame_serializer.sv
// Randomized bench for vlc_frame_serializer (default parameters); follows MANCHESTER_EN like the DUT.
module tb_vlc_frame_serializer;

  localparam int CPH      = 4;
  localparam int PRE      = 4;
  localparam int PAY      = 8;
  localparam int BIT_CYC  = 2 * CPH;
  localparam int BYTE_CYC = 8 * BIT_CYC;
  localparam int FRAME    = (PRE + 1 + PAY) * BYTE_CYC;
`ifdef MANCHESTER_EN
  localparam bit MAN = 1'b1;
`else
  localparam bit MAN = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst_n;
  logic       start;
  logic [7:0] byteIn = 8'h00;
  logic       byteValid = 1'b0;
  logic       pop, ledOut, busy, done, underrun;
  logic [4:0] outs;

  logic [7:0] buf_q[$];
  logic [7:0] exp_q[$];
  int         n_chk = 0;
  int         n_pass = 0;

  vlc_frame_serializer dut (
    .clk(clk), .rst_n(rst_n), .start(start), .byteIn(byteIn), .byteValid(byteValid),
    .pop(pop), .ledOut(ledOut), .busy(busy), .done(done), .underrun(underrun)
  );

  always #5 clk = ~clk;
  assign outs = {busy, ledOut, pop, done, underrun};

  // Byte buffer: a pop seen this cycle presents the head byte from the next edge on.
  always @(negedge clk) begin
    if (pop && buf_q.size() > 0) byteIn = buf_q.pop_front();
    byteValid = (buf_q.size() > 0);
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  task automatic load(input int n);
    logic [7:0] b;
    for (int i = 0; i < n; i++) begin
      b = 8'($urandom_range(0, 255));
      buf_q.push_back(b);
      exp_q.push_back(b);
    end
  endtask

  // Called just after the accepting edge; checks {busy,led,pop,done,underrun} each cycle.
  task automatic check_frame(input int stop_at);
    logic [7:0] fb[PRE + 1 + PAY];
    logic [7:0] b;
    logic [4:0] e;
    int avail, n_pop, len, bi, hf;
    logic p, lvl;
    avail = exp_q.size();
    n_pop = (avail < PAY) ? avail : PAY;
    for (int i = 0; i < PRE; i++) fb[i] = 8'h55;
    fb[PRE] = 8'hA7;
    for (int i = 0; i < PAY; i++) fb[PRE + 1 + i] = (i < n_pop) ? exp_q.pop_front() : 8'h00;
    len = (avail >= PAY) ? FRAME : (PRE + avail) * BYTE_CYC + 7 * BIT_CYC;
    for (int t = 0; t <= len; t++) begin
      if (t == stop_at) return;
      @(negedge clk);
      if (t < len) begin
        b   = fb[t / BYTE_CYC];
        bi  = 7 - (t % BYTE_CYC) / BIT_CYC;
        hf  = (t % BIT_CYC) / CPH;
        lvl = MAN ? (b[bi] ^ hf[0]) : b[bi];
        p   = 1'b0;
        for (int j = 0; j < n_pop; j++)
          if (t == (PRE + j) * BYTE_CYC + 7 * BIT_CYC) p = 1'b1;
        e = {1'b1, lvl, p, 1'b0, 1'b0};
      end else begin
        e = {3'b000, avail >= PAY, avail < PAY};
      end
      check($sformatf("frame t=%0d", t), 32'(outs), 32'(e));
    end
  endtask

  task automatic run_frame(input int n_avail);
    repeat (2) @(negedge clk);
    load(n_avail);
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    check_frame(-1);
    check("buf_drained", 32'(buf_q.size()), 32'(n_avail > PAY ? n_avail - PAY : 0));
  endtask

  initial begin
    rst_n = 1'b0;
    start = 1'b0;
    repeat (3) @(negedge clk);
    check("reset_outs", 32'(outs), 32'h0);
    rst_n = 1'b1;

    for (int k = 0; k < 3; k++) run_frame(PAY);
    run_frame(3);
    for (int k = 0; k < 2; k++) run_frame($urandom_range(0, PAY - 1));

    // start held high: second frame must begin one cycle after the done cycle
    repeat (2) @(negedge clk);
    load(2 * PAY);
    start = 1'b1;
    @(posedge clk);
    #1;
    check_frame(-1);
    @(negedge clk);
    check("b2b_gap", 32'(outs), 32'h0);
    @(posedge clk);
    #1;
    check_frame(-1);
    start = 1'b0;

    // reset in the middle of the payload
    repeat (2) @(negedge clk);
    load(PAY);
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    check_frame(500);
    #2 rst_n = 1'b0;
    #1 check("rst_async", 32'(outs), 32'h0);
    buf_q.delete();
    exp_q.delete();
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      check("idle_after_rst", 32'(outs), 32'h0);
    end
    run_frame(PAY);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
